enc4x2_queue: RTL and testbench
===============================

# enc4x2_queue

Sequential 4-to-2 request encoder: the encoding counterpart of the 2-to-4 decoder in the COA datapath. It latches one-hot or multi-hot request pulses on four lines into a pending set. Each pending request is emitted as a 2-bit binary code over a valid/ready handshake, one code per transfer. It sits upstream of the 2-to-4 decoder, so decoding an emitted code regenerates the original request line.

## Interface
Parameters:
- RR_MODE, default 0: 0 = fixed priority (line 3 highest, line 0 lowest); 1 = round-robin starting after the last emitted code.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- Enable, input, 1: capture enable for req; 0 masks new captures only.
- req, input, 4: request lines, sampled each rising edge; bit i requests code i.
- out_valid, output, 1: out_code holds a valid code.
- out_ready, input, 1: consumer accepts the code this cycle.
- out_code, output, 2: binary index of the granted request line.
- pending, output, 4: requests captured but not yet loaded into the output stage.
- overrun, output, 1: sticky flag for a request that arrived while its line was already pending.

## Operation
- Pending register P[3:0] is updated every edge: P_next = (P & ~load_mask) | (Enable ? req : 0).
  - load_mask is the one-hot bit of the line moving into the output stage this cycle, else 0.
  - A line set by req and cleared by load_mask in the same cycle stays set: the new request is kept.
- Output stage: the out_valid/out_code register.
  - It loads when empty (out_valid=0) or when a handshake occurs (out_valid & out_ready).
  - If P is non-zero, it loads the selected index and sets out_valid=1.
  - Otherwise it clears out_valid.
- Selection is made from P only; req that has not yet been registered is never selected directly.
  - RR_MODE=0: highest set bit of P.
  - RR_MODE=1: first set bit of P scanning upward from (last_code+1) mod 4, wrapping 3→0. last_code resets to 3, so the first scan starts at line 0.
- While out_valid=1 and out_ready=0, out_code holds stable and P keeps accumulating.
- overrun is set when Enable=1, req[i]=1, P[i]=1 and load_mask[i]=0 for any i. It clears only on reset.
- Enable=0 does not flush P or the output stage; captured work still drains.
- Reset values: P=0, out_valid=0, out_code=0, overrun=0, last_code=3.

## Timing
- Latency: req[i] high before edge k → P[i]=1 after edge k → out_valid=1, out_code=i after edge k+1, if the output stage is free.
- Throughput: one code per cycle while out_ready=1 and P is non-zero.
- A handshake at edge k loads the next code at the same edge, with no bubble.
- pending and overrun are registered outputs. out_code is meaningless when out_valid=0 but holds its last value; it is not required to return to 0.
- When rst_n is asserted mid-transfer, all state clears immediately, with no clock edge required. An in-flight code is lost.
- After rst_n deasserts, the first capture occurs at the next rising edge.

## Structure
- Shared package coa_dec_pkg holds:
  - LINES=4 and CODE_W=2;
  - the typedef code_t (logic [1:0]);
  - the typedef line_t (logic [3:0]).
  The 2-to-4 decoder also uses this package.
- One combinational sub-module, pri_pick4. Inputs are mask[3:0], start[1:0] and rr. Outputs are found and idx[1:0].
  - Fixed mode ignores start.
  - The top level contains only the registers and the handshake logic.

## Test plan
- Reset/idle: rst_n=0, then release with req=0 → out_valid=0, pending=0000, overrun=0 for 5 cycles.
- Single request: Enable=1, req=0100 for one cycle, out_ready=1 → out_valid=1 with out_code=2 two edges later for one cycle; pending returns to 0000.
- Fixed-priority burst (RR_MODE=0):
  - Step 1: req=1011 for one cycle with out_ready=0 → pending=1011.
  - Step 2: raise out_ready → codes 3, 1, 0 on consecutive cycles.
- Round-robin (RR_MODE=1):
  - Hold req=1111 for one cycle, out_ready=1 → codes 0, 1, 2, 3.
  - Then assert req=0001 and req=1000 together → code 0, then code 3.
- Backpressure/overrun, with out_ready=0 throughout:
  - req=0010 → out_code=1 held stable for 10 cycles.
  - Then req=0010 again → pending=0010.
  - Then a third req=0010 → overrun=1.
  - Enable=0 with req=1111 → pending unchanged.
- Asynchronous reset mid-stream: with out_valid=1 and pending=0110, drop rst_n between edges → all outputs zero before the next edge.

Source files
------------

// File: rtl/coa_dec_pkg.sv
// Shared COA decode/encode definitions: line count, code width and the
// code/line typedefs used by the 2-to-4 decoder and the 4-to-2 encoder queue.
package coa_dec_pkg;

    localparam int unsigned LINES  = 4;
    localparam int unsigned CODE_W = 2;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [LINES-1:0]  line_t;

endpackage : coa_dec_pkg

// File: rtl/pri_pick4.sv
// Combinational 4-line picker.
//   mask  : candidate lines
//   start : first line scanned in round-robin mode (ignored when rr=0)
//   rr    : 0 = highest set line wins, 1 = first set line at/after start, wrapping
//   found : any line set in mask
//   idx   : index of the chosen line (0 when found=0)
module pri_pick4
    import coa_dec_pkg::*;
(
    input  line_t mask,
    input  code_t start,
    input  logic  rr,
    output logic  found,
    output code_t idx
);

    code_t pos;

    always_comb begin
        found = |mask;
        idx   = '0;
        pos   = '0;
        if (!rr) begin
            // Ascending scan: the last hit is the highest set line.
            for (int i = 0; i < int'(LINES); i++) begin
                if (mask[i]) idx = code_t'(i);
            end
        end else begin
            // Descending offset scan: the last hit is the nearest line at/after start.
            // pos wraps naturally in CODE_W bits.
            for (int k = int'(LINES) - 1; k >= 0; k--) begin
                pos = start + code_t'(k);
                if (mask[pos]) idx = pos;
            end
        end
    end

endmodule : pri_pick4

// File: rtl/enc4x2_queue.sv
// Sequential 4-to-2 request encoder. Captures request pulses into a pending
// set and emits each pending line as a 2-bit code over valid/ready.
//   clk, rst_n          : clock, async active-low reset
//   Enable              : capture enable for req (draining continues when low)
//   req[3:0]            : request lines, bit i requests code i
//   out_valid/out_ready : output handshake
//   out_code[1:0]       : granted line index
//   pending[3:0]        : captured requests not yet in the output stage
//   overrun             : sticky, a request hit a line that was still pending
module enc4x2_queue
    import coa_dec_pkg::*;
#(
    parameter int unsigned RR_MODE = 0
)(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  Enable,
    input  line_t req,
    output logic  out_valid,
    input  logic  out_ready,
    output code_t out_code,
    output line_t pending,
    output logic  overrun
);

    line_t pend_q, pend_d;
    logic  valid_q, valid_d;
    code_t code_q, code_d;
    logic  overrun_q, overrun_d;
    code_t last_q, last_d;

    logic  pick_found;
    code_t pick_idx;
    code_t scan_start;
    logic  load_en;
    line_t load_mask;
    line_t cap;

    assign scan_start = last_q + code_t'(1);

    pri_pick4 u_pick (
        .mask  (pend_q),
        .start (scan_start),
        .rr    (RR_MODE != 0),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next-state: pending set, output stage, sticky overrun, round-robin pointer.
    always_comb begin
        cap       = Enable ? req : '0;
        load_en   = !valid_q || out_ready;
        load_mask = '0;
        valid_d   = valid_q;
        code_d    = code_q;
        last_d    = last_q;
        if (load_en && pick_found) begin
            load_mask = line_t'(1) << pick_idx;
        end
        // A fresh request on the line being loaded survives the clear.
        pend_d    = (pend_q & ~load_mask) | cap;
        overrun_d = overrun_q | (|(cap & pend_q & ~load_mask));
        if (load_en) begin
            valid_d = pick_found;
            if (pick_found) begin
                code_d = pick_idx;
                last_d = pick_idx;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= '0;
            valid_q   <= 1'b0;
            code_q    <= '0;
            overrun_q <= 1'b0;
            last_q    <= code_t'(LINES - 1);
        end else begin
            pend_q    <= pend_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            overrun_q <= overrun_d;
            last_q    <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_code  = code_q;
    assign pending   = pend_q;
    assign overrun   = overrun_q;

endmodule : enc4x2_queue

// File: tb/tb_enc4x2_queue.sv
// Directed bench for enc4x2_queue: one fixed-priority and one round-robin
// instance share the same stimulus; each section checks the relevant one.
module tb_enc4x2_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       Enable;
    logic [3:0] req;
    logic       out_ready;

    logic       v0, v1;
    logic [1:0] c0, c1;
    logic [3:0] p0, p1;
    logic       o0, o1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    enc4x2_queue #(.RR_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .Enable(Enable), .req(req),
        .out_valid(v0), .out_ready(out_ready), .out_code(c0),
        .pending(p0), .overrun(o0)
    );

    enc4x2_queue #(.RR_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .Enable(Enable), .req(req),
        .out_valid(v1), .out_ready(out_ready), .out_code(c1),
        .pending(p1), .overrun(o1)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit before checks/drives.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; Enable = 1'b0; req = 4'b0000; out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset / idle
        do_reset();
        chk("rst_valid", {3'b0, v0}, 4'b0000);
        chk("rst_code", {2'b0, c0}, 4'b0000);
        chk("rst_pend", p0, 4'b0000);
        chk("rst_ovr", {3'b0, o0}, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_valid", {3'b0, v0}, 4'b0000);
            chk("idle_pend", p0, 4'b0000);
            chk("idle_ovr", {3'b0, o0}, 4'b0000);
        end

        // Single request, two-edge latency
        Enable = 1'b1; out_ready = 1'b1; req = 4'b0100;
        step();
        req = 4'b0000;
        chk("single_pend", p0, 4'b0100);
        chk("single_v_early", {3'b0, v0}, 4'b0000);
        step();
        chk("single_valid", {3'b0, v0}, 4'b0001);
        chk("single_code", {2'b0, c0}, 4'b0010);
        chk("single_pend0", p0, 4'b0000);
        step();
        chk("single_drop", {3'b0, v0}, 4'b0000);

        // Fixed-priority burst
        do_reset();
        Enable = 1'b1; out_ready = 1'b0; req = 4'b1011;
        step();
        req = 4'b0000;
        chk("fp_pend", p0, 4'b1011);
        step();
        chk("fp_v3", {3'b0, v0}, 4'b0001);
        chk("fp_c3", {2'b0, c0}, 4'b0011);
        chk("fp_pend2", p0, 4'b0011);
        out_ready = 1'b1;
        step();
        chk("fp_c1", {2'b0, c0}, 4'b0001);
        chk("fp_v1", {3'b0, v0}, 4'b0001);
        step();
        chk("fp_c0", {2'b0, c0}, 4'b0000);
        chk("fp_v0", {3'b0, v0}, 4'b0001);
        chk("fp_pend_empty", p0, 4'b0000);
        step();
        chk("fp_done", {3'b0, v0}, 4'b0000);

        // Same-cycle set and load: the new request is kept, no overrun
        do_reset();
        Enable = 1'b1; out_ready = 1'b1; req = 4'b0100;
        step();
        step();
        req = 4'b0000;
        chk("keep_pend", p0, 4'b0100);
        chk("keep_code", {2'b0, c0}, 4'b0010);
        chk("keep_ovr", {3'b0, o0}, 4'b0000);

        // Round-robin
        do_reset();
        Enable = 1'b1; out_ready = 1'b1; req = 4'b1111;
        step();
        req = 4'b0000;
        chk("rr_pend", p1, 4'b1111);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_valid", {3'b0, v1}, 4'b0001);
            chk("rr_code", {2'b0, c1}, 4'(i));
        end
        step();
        chk("rr_drain", {3'b0, v1}, 4'b0000);
        req = 4'b1001;
        step();
        req = 4'b0000;
        chk("rr2_pend", p1, 4'b1001);
        step();
        chk("rr2_c0", {2'b0, c1}, 4'b0000);
        chk("rr2_v0", {3'b0, v1}, 4'b0001);
        step();
        chk("rr2_c3", {2'b0, c1}, 4'b0011);
        chk("rr2_v3", {3'b0, v1}, 4'b0001);
        step();
        chk("rr2_done", {3'b0, v1}, 4'b0000);

        // Backpressure and overrun
        do_reset();
        Enable = 1'b1; out_ready = 1'b0; req = 4'b0010;
        step();
        req = 4'b0000;
        step();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", {3'b0, v0}, 4'b0001);
            chk("bp_code", {2'b0, c0}, 4'b0001);
            step();
        end
        req = 4'b0010;
        step();
        req = 4'b0000;
        chk("bp_pend", p0, 4'b0010);
        chk("bp_no_ovr", {3'b0, o0}, 4'b0000);
        step();
        chk("bp_pend_hold", p0, 4'b0010);
        req = 4'b0010;
        step();
        req = 4'b0000;
        chk("bp_ovr", {3'b0, o0}, 4'b0001);
        chk("bp_pend3", p0, 4'b0010);
        Enable = 1'b0; req = 4'b1111;
        step();
        req = 4'b0000;
        chk("mask_pend", p0, 4'b0010);
        chk("mask_ovr_sticky", {3'b0, o0}, 4'b0001);
        chk("mask_code", {2'b0, c0}, 4'b0001);

        // Asynchronous reset between edges
        do_reset();
        Enable = 1'b1; out_ready = 1'b0; req = 4'b1000;
        step();
        req = 4'b0110;
        step();
        req = 4'b0000;
        chk("ar_pre_valid", {3'b0, v0}, 4'b0001);
        chk("ar_pre_code", {2'b0, c0}, 4'b0011);
        chk("ar_pre_pend", p0, 4'b0110);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {3'b0, v0}, 4'b0000);
        chk("ar_code", {2'b0, c0}, 4'b0000);
        chk("ar_pend", p0, 4'b0000);
        chk("ar_ovr", {3'b0, o0}, 4'b0000);
        chk("ar_valid_rr", {3'b0, v1}, 4'b0000);
        chk("ar_pend_rr", p1, 4'b0000);
        step();
        rst_n = 1'b1;
        step();
        chk("ar_after_valid", {3'b0, v0}, 4'b0000);
        chk("ar_after_pend", p0, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_enc4x2_queue
